// File: rtl/ls_mem_sequencer_pkg.sv
// Shared constants and helpers for the load/store sequencer: access sizes,
// FSM state encoding and the size-to-beat-count mapping.
package mips_ls_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            LS_BYTE: beat_count = 3'd1;
            LS_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ls_mem_sequencer_if.sv
// Byte-wide data-memory bus with a req/ack handshake; the sequencer is the
// master, the data memory the slave.
interface ls_mem_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ls_mem_sequencer_extend.sv
// Load-result extension: widens an assembled byte/halfword to 32 bits with
// sign or zero fill; words pass through. Shared with the write-back path.
module ls_extend
    import mips_ls_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_data
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        o_data = i_raw;
        case (i_size)
            LS_BYTE: o_data = {{24{i_sign_ext & i_raw[7]}},  i_raw[7:0]};
            LS_HALF: o_data = {{16{i_sign_ext & i_raw[15]}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/ls_mem_sequencer.sv
// Load/store execution unit: turns one EX-stage memory request into 1/2/4
// big-endian byte beats on the req/ack bus and returns the extended load word.
module ls_mem_sequencer
    import mips_ls_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        LScontrol,
    input  logic              SignExtend,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    ls_mem_sequencer_if.master mem
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wshift;
    logic [31:0]       r_raw;
    logic [31:0]       r_rdata;
    logic [1:0]        r_size;
    logic [2:0]        r_n;
    logic [1:0]        r_k;
    logic              r_sext;
    logic              r_we;
    logic              r_err;
    logic [TW-1:0]     r_tcnt;

    logic              w_xfer;
    logic              w_accept;
    logic              w_bad;
    logic              w_last;
    logic              w_timeout;
    logic [TW-1:0]     w_tcnt_nxt;
    logic [31:0]       w_raw_nxt;
    logic [31:0]       w_ext;
    logic [31:0]       w_wshift_init;

    assign w_xfer   = (r_state == ST_XFER);
    assign w_accept = (r_state == ST_IDLE) && start && (MemRead || MemWrite);
    assign w_bad    = (MemRead && MemWrite) || (LScontrol == LS_ILL)
                   || ((LScontrol == LS_HALF) && addr[0])
                   || ((LScontrol == LS_WORD) && (addr[1:0] != 2'b00));

    assign w_last     = ({1'b0, r_k} == (r_n - 3'd1));
    assign w_tcnt_nxt = r_tcnt + 1'b1;
    assign w_timeout  = w_xfer && !mem.mem_ack && (w_tcnt_nxt == TW'(TIMEOUT));

    // Shifting each byte in from the right leaves beat k at byte N-1-k.
    assign w_raw_nxt = {r_raw[23:0], mem.mem_rdata};

    // Store data is left-justified so the beat byte is always the top byte.
    always_comb begin
        w_wshift_init = wdata;
        case (LScontrol)
            LS_BYTE: w_wshift_init = {wdata[7:0],  24'h0};
            LS_HALF: w_wshift_init = {wdata[15:0], 16'h0};
            default: w_wshift_init = wdata;
        endcase
    end

    ls_extend u_extend (
        .i_raw      (w_raw_nxt),
        .i_size     (r_size),
        .i_sign_ext (r_sext),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wshift <= '0;
            r_raw    <= '0;
            r_rdata  <= '0;
            r_size   <= LS_BYTE;
            r_n      <= 3'd1;
            r_k      <= '0;
            r_sext   <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= addr;
                        r_wshift <= w_wshift_init;
                        r_raw    <= '0;
                        r_size   <= LScontrol;
                        r_n      <= beat_count(LScontrol);
                        r_k      <= '0;
                        r_sext   <= SignExtend;
                        r_we     <= MemWrite;
                        r_tcnt   <= '0;
                        r_err    <= w_bad;
                        r_state  <= w_bad ? ST_FIN : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (mem.mem_ack) begin
                        r_raw    <= w_raw_nxt;
                        r_wshift <= {r_wshift[23:0], 8'h0};
                        r_tcnt   <= '0;
                        if (w_last) begin
                            r_state <= ST_FIN;
                            if (!r_we) r_rdata <= w_ext;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_tcnt <= w_tcnt_nxt;
                    end
                end
                ST_FIN: begin
                    r_err   <= 1'b0;
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = w_xfer;
    assign done  = (r_state == ST_FIN);
    assign err   = done && r_err;
    assign rdata = r_rdata;

    assign mem.mem_req   = w_xfer;
    assign mem.mem_we    = w_xfer && r_we;
    assign mem.mem_addr  = r_addr + ADDR_W'(r_k);
    assign mem.mem_wdata = r_wshift[31:24];

endmodule

// File: tb/tb_ls_mem_sequencer.sv
// Self-checking bench for ls_mem_sequencer: directed vector table, hand
// sequences for timeout/reset/ignored starts, then random ops against a model.
module tb_ls_mem_sequencer;
    import mips_ls_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, MemRead, MemWrite, SignExtend;
    logic [1:0]  LScontrol;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;

    ls_mem_sequencer_if #(.ADDR_W(32)) mem_if ();

    ls_mem_sequencer #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .LScontrol  (LScontrol),
        .SignExtend (SignExtend),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_nreq;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;

    logic [7:0]  tb_mem  [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] ref_rdata;
    beat_t       beat_q[$];
    int          cur_delay = 0;
    int          cur_hang  = -1;
    int          beat_i    = 0;
    bit          stray_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        tb_mem[a[9:0]]  = d;
        ref_mem[a[9:0]] = d;
    endtask

    // Data memory: acks each beat after cur_delay wait cycles, never acks beat
    // cur_hang, and optionally wiggles ack/rdata while no request is pending.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_if.mem_req && !rst) begin
                if (beat_i != cur_hang && wait_cnt >= cur_delay) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = tb_mem[mem_if.mem_addr[9:0]];
                    if (mem_if.mem_we) tb_mem[mem_if.mem_addr[9:0]] = mem_if.mem_wdata;
                    beat_q.push_back('{mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata});
                    beat_i++;
                    wait_cnt = 0;
                end else begin
                    mem_if.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_if.mem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_if.mem_rdata = 8'($urandom);
                wait_cnt = 0;
            end
        end
    end

    // Issue one request; report start-to-done latency, err, rdata and the
    // number of cycles mem_req was high.
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] size, input bit sext,
                          input logic [31:0] a, input logic [31:0] wd, input int delay,
                          input int hang, input int hold,
                          output int lat, output logic e, output logic [31:0] rv,
                          output int nreq);
        bit got;
        beat_q.delete();
        beat_i    = 0;
        cur_delay = delay;
        cur_hang  = hang;
        lat = 0; e = 1'bx; rv = 'x; nreq = 0; got = 1'b0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; LScontrol = size; SignExtend = sext;
        addr = a; wdata = wd; start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c >= hold) start = 1'b0;
            if (mem_if.mem_req) nreq++;
            if (done) begin
                lat = c; e = err; rv = rdata; got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
    endtask

    // Reference model: derives the transfer from the access rules directly.
    task automatic model_op(input bit rd, input bit wr, input logic [1:0] size, input bit sext,
                            input logic [31:0] a, input logic [31:0] wd, input int delay,
                            input int hang,
                            output int lat, output bit e, output logic [31:0] rv,
                            output int nreq, output beat_t eb[$]);
        int     n, nb;
        bit     bad;
        longint val;
        logic [31:0] ba, sh;
        eb.delete();
        n   = (size == LS_BYTE) ? 1 : (size == LS_HALF) ? 2 : 4;
        bad = (rd && wr) || (size == LS_ILL) || ((a % n) != 0);
        if (bad) begin
            lat = 1; e = 1'b1; rv = ref_rdata; nreq = 0;
            return;
        end
        nb = (hang >= 0 && hang < n) ? hang : n;
        for (int i = 0; i < nb; i++) begin
            ba = a + i;
            sh = wd >> (8 * (n - 1 - i));
            eb.push_back('{ba, wr, sh[7:0]});
            if (wr) ref_mem[ba[9:0]] = sh[7:0];
        end
        if (nb < n) begin
            nreq = nb * (delay + 1) + TIMEOUT;
            lat  = nreq + 1;
            e    = 1'b1;
            rv   = ref_rdata;
            return;
        end
        nreq = n * (delay + 1);
        lat  = nreq + 1;
        e    = 1'b0;
        if (rd) begin
            val = 0;
            for (int i = 0; i < n; i++) begin
                ba  = a + i;
                val = val * 256 + longint'(ref_mem[ba[9:0]]);
            end
            if (sext && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                val = val - (longint'(1) << (8 * n));
            ref_rdata = val[31:0];
        end
        rv = ref_rdata;
    endtask

    task automatic check_beats(input string tag, input beat_t eb[$]);
        check({tag, "_nbeats"}, 32'(beat_q.size()), 32'(eb.size()));
        for (int i = 0; i < eb.size() && i < beat_q.size(); i++) begin
            check($sformatf("%s_b%0d_addr", tag, i), beat_q[i].addr, eb[i].addr);
            check($sformatf("%s_b%0d_we", tag, i), 32'(beat_q[i].we), 32'(eb[i].we));
            if (eb[i].we)
                check($sformatf("%s_b%0d_wdata", tag, i), 32'(beat_q[i].wdata), 32'(eb[i].wdata));
        end
    endtask

    initial begin
        vec_t        vecs[$];
        beat_t       eb[$];
        int          lat, nreq, m_lat, m_nreq, act_cnt;
        logic        e;
        bit          m_e;
        logic [31:0] rv, m_rv, a, wd;
        logic [1:0]  sz;
        bit          rd, wr, sx;
        int          dly, hng, nn, pick;

        vecs.push_back('{"lw_100",     1, 0, LS_WORD, 0, 32'h100, 32'h0,        0, 5,  0, 32'h12345678, 4});
        vecs.push_back('{"lb_203_s",   1, 0, LS_BYTE, 1, 32'h203, 32'h0,        0, 2,  0, 32'hFFFFFF80, 1});
        vecs.push_back('{"lbu_203",    1, 0, LS_BYTE, 0, 32'h203, 32'h0,        0, 2,  0, 32'h00000080, 1});
        vecs.push_back('{"lh_40_d3",   1, 0, LS_HALF, 1, 32'h040, 32'h0,        3, 9,  0, 32'hFFFFFF7E, 8});
        vecs.push_back('{"sw_10",      0, 1, LS_WORD, 0, 32'h010, 32'hAABBCCDD, 0, 5,  0, 32'hFFFFFF7E, 4});
        vecs.push_back('{"lw_102_mis", 1, 0, LS_WORD, 0, 32'h102, 32'h0,        0, 1,  1, 32'hFFFFFF7E, 0});
        vecs.push_back('{"sh_101_mis", 0, 1, LS_HALF, 0, 32'h101, 32'h1234,     0, 1,  1, 32'hFFFFFF7E, 0});
        vecs.push_back('{"ill_size",   1, 0, LS_ILL,  0, 32'h000, 32'h0,        0, 1,  1, 32'hFFFFFF7E, 0});
        vecs.push_back('{"both_ctl",   1, 1, LS_BYTE, 0, 32'h000, 32'h0,        0, 1,  1, 32'hFFFFFF7E, 0});
        vecs.push_back('{"lhu_10_d1",  1, 0, LS_HALF, 0, 32'h010, 32'h0,        1, 5,  0, 32'h0000AABB, 4});
        vecs.push_back('{"lw_10_d2",   1, 0, LS_WORD, 0, 32'h010, 32'h0,        2, 13, 0, 32'hAABBCCDD, 12});
        vecs.push_back('{"lb_13_s",    1, 0, LS_BYTE, 1, 32'h013, 32'h0,        0, 2,  0, 32'hFFFFFFDD, 1});

        for (int i = 0; i < 1024; i++) poke(32'(i), 8'($urandom));
        poke(32'h100, 8'h12); poke(32'h101, 8'h34); poke(32'h102, 8'h56); poke(32'h103, 8'h78);
        poke(32'h203, 8'h80);
        poke(32'h040, 8'hFF); poke(32'h041, 8'h7E);
        ref_rdata = 32'h0;

        rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        LScontrol = LS_BYTE; SignExtend = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check("rst_err",       32'(err), 32'd0);
        check("rst_rdata",     rdata, 32'h0);
        check("rst_mem_req",   32'(mem_if.mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_if.mem_we), 32'd0);
        check("rst_mem_addr",  mem_if.mem_addr, 32'h0);
        check("rst_mem_wdata", 32'(mem_if.mem_wdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sext, vecs[i].addr,
                   vecs[i].wdata, vecs[i].delay, -1, 1, lat, e, rv, nreq);
            model_op(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sext, vecs[i].addr,
                     vecs[i].wdata, vecs[i].delay, -1, m_lat, m_e, m_rv, m_nreq, eb);
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_err"},   32'(e), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_rdata"}, rv, vecs[i].exp_rdata);
            check({vecs[i].name, "_nreq"},  32'(nreq), 32'(vecs[i].exp_nreq));
            check_beats(vecs[i].name, eb);
        end

        // start with neither control set is ignored
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; LScontrol = LS_WORD; addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        act_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || mem_if.mem_req) act_cnt++;
        end
        check("nop_start_ignored", 32'(act_cnt), 32'd0);

        // start held while busy must not queue a second transfer
        run_op(1, 0, LS_WORD, 0, 32'h100, 32'h0, 0, -1, 3, lat, e, rv, nreq);
        check("hold_lat",   32'(lat), 32'd5);
        check("hold_rdata", rv, 32'h12345678);
        ref_rdata = 32'h12345678;
        act_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || mem_if.mem_req) act_cnt++;
        end
        check("hold_no_requeue", 32'(act_cnt), 32'd0);

        // ack never arrives: 15 wait cycles then err, rdata untouched
        run_op(1, 0, LS_WORD, 0, 32'h040, 32'h0, 0, 0, 1, lat, e, rv, nreq);
        check("tmo_lat",   32'(lat), 32'd16);
        check("tmo_err",   32'(e), 32'd1);
        check("tmo_nreq",  32'(nreq), 32'd15);
        check("tmo_rdata", rv, 32'h12345678);
        check("tmo_nbeats", 32'(beat_q.size()), 32'd0);

        // reset during beat 2 drops mem_req at once and produces no done
        beat_q.delete(); beat_i = 0; cur_delay = 0; cur_hang = -1;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; LScontrol = LS_WORD; SignExtend = 1'b0;
        addr = 32'h100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstmid_req_before",  32'(mem_if.mem_req), 32'd1);
        check("rstmid_addr_before", mem_if.mem_addr, 32'h102);
        rst = 1'b1;
        #1;
        check("rstmid_req_dropped", 32'(mem_if.mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        act_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || mem_if.mem_req) act_cnt++;
        end
        check("rstmid_no_done", 32'(act_cnt), 32'd0);
        check("rstmid_rdata",   rdata, 32'h0);
        ref_rdata = 32'h0;

        stray_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            pick = $urandom_range(0, 9);
            rd   = (pick <= 5);
            wr   = (pick == 0) || (pick > 5);
            sz   = ($urandom_range(0, 7) == 0) ? LS_ILL : 2'($urandom_range(0, 2));
            nn   = (sz == LS_BYTE) ? 1 : (sz == LS_HALF) ? 2 : 4;
            a    = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~32'(nn - 1);
            wd   = $urandom;
            sx   = 1'($urandom_range(0, 1));
            dly  = $urandom_range(0, 3);
            hng  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            run_op(rd, wr, sz, sx, a, wd, dly, hng, 1, lat, e, rv, nreq);
            model_op(rd, wr, sz, sx, a, wd, dly, hng, m_lat, m_e, m_rv, m_nreq, eb);
            check($sformatf("rnd%0d_lat", t),   32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_err", t),   32'(e), 32'(m_e));
            check($sformatf("rnd%0d_rdata", t), rv, m_rv);
            check($sformatf("rnd%0d_nreq", t),  32'(nreq), 32'(m_nreq));
            check_beats($sformatf("rnd%0d", t), eb);
        end
        stray_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ls_mem_sequencer.md
Name: ls_mem_sequencer

Overview:
- Load/store execution unit.
- Consumes the decoder's memory controls (MemRead, MemWrite, LScontrol, SignExtend) plus the ALU-computed address and the rt store data.
- Sequences byte-wide transfers on an 8-bit data-memory bus with a req/ack handshake, then returns the assembled, extended load word.
- Sits between the EX stage and data memory; the core stalls while busy=1.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 15, maximum cycles a beat's mem_req may wait for mem_ack before the transfer aborts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe from EX.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- LScontrol  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- SignExtend  in  1  1 sign-extends byte/halfword loads, 0 zero-extends.
- addr  in  ADDR_W  effective byte address.
- wdata  in  32  store data; uses the low 1/2/4 bytes.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, illegal, or timeout.
- rdata  out  32  load result; held until next accepted start.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  8  beat write byte.
- mem_rdata  in  8  beat read byte.
- mem_ack  in  1  beat complete; sampled while mem_req=1.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata, beat counter and timeout counter = 0.
- States: IDLE, XFER, FIN.
- IDLE:
  - Accept when start=1 and MemRead XOR MemWrite.
  - If start=1 and both controls are 0: ignore.
  - If start=1 and both controls are 1: treat as illegal.
  - Capture addr, wdata, size, SignExtend and direction.
- Beat count N: byte 1, halfword 2, word 4.
- Error on accept (LScontrol=11, both controls set, halfword with addr[0]≠0, word with addr[1:0]≠0):
  - Go to FIN with err=1.
  - No mem_req is ever asserted.
  - rdata is unchanged.
- Otherwise go to XFER, beat k=0, busy=1 from the cycle after accept.
- XFER:
  - mem_req=1, mem_addr=addr+k, mem_we=direction.
  - mem_wdata = wdata byte (N-1-k), big-endian.
  - On a cycle with mem_ack=1, read byte k is placed at result bits [8(N-1-k)+7 : 8(N-1-k)].
  - Then k increments; after beat N-1, go to FIN.
  - Beats are back-to-back: mem_req stays high across consecutive beats.
- Ack timing: a zero-wait memory (ack in the same cycle as req) gives start-to-done latency N+1 cycles (done asserted in cycle N+1 after the accept edge).
- Timeout:
  - A counter resets on each new beat and increments each cycle that mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT, drop mem_req and go to FIN with err=1.
  - Any store bytes already written stay written.
  - rdata is unchanged.
- FIN:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - On a successful load, rdata is updated in this cycle: byte/halfword result sign- or zero-extended per the captured SignExtend; word passed through.
  - Stores never change rdata.
- start while busy or in FIN: ignored, no queuing.
- mem_ack while mem_req=0: ignored.
- rst mid-transfer: mem_req drops immediately (asynchronously); the partial transfer is abandoned and no done is generated.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package mips_ls_pkg:
  - constants LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10;
  - state encoding IDLE/XFER/FIN;
  - function size→beat count.
- Sub-module ls_extend (combinational): takes the assembled 32-bit raw data, the size and SignExtend; produces the final rdata value. It is reused by the write-back path.

Test Plan:
- lw, addr=0x100, memory bytes 0x12,0x34,0x56,0x78, zero-wait ack -> four beats at 0x100–0x103; done at cycle 5; rdata=0x12345678; err=0.
- lb, SignExtend=1, byte 0x80 at 0x203; then lbu on the same byte -> rdata=0xFFFFFF80, then 0x00000080.
- lh, SignExtend=1, bytes 0xFF,0x7E at 0x40, ack delayed 3 cycles per beat -> mem_req held through the waits; rdata=0xFFFFFF7E.
- sw, wdata=0xAABBCCDD, addr=0x10 -> beats write 0xAA,0xBB,0xCC,0xDD at 0x10–0x13 with mem_we=1; rdata unchanged.
- lw at 0x102, and sh at 0x101 -> mem_req never asserted; done=1, err=1 one cycle after accept.
- lw, ack never returns -> after 15 wait cycles mem_req drops, done=1, err=1; separately, rst asserted during beat 2 drops mem_req immediately and no done is produced.
